// File: rtl/joy_scan_ctrl.sv
// Scan controller for a two-joystick PISO shift-register chain: generates load/shift
// timing from a programmable tick, deserialises 16 bits and publishes active-low buttons.
module joy_scan_ctrl #(
    parameter int DIV_W  = 8,
    parameter bit FILTER = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             continuous_i,
    input  logic             scan_req_i,
    input  logic             joy_data_i,
    output logic             joy_clk_o,
    output logic             joy_load_n_o,
    output logic             scan_busy_o,
    output logic [7:0]       joy1_o,
    output logic [7:0]       joy2_o,
    output logic             frame_valid_o,
    output logic             changed_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_SHIFT  = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    logic [1:0]       state_q,  state_d;
    logic [DIV_W-1:0] div_q,    div_d;
    logic [DIV_W-1:0] cnt_q,    cnt_d;
    logic [4:0]       tcnt_q,   tcnt_d;
    logic             pend_q,   pend_d;
    logic [15:0]      raw_q,    raw_d;
    logic [15:0]      prev_q,   prev_d;
    logic [15:0]      out_q,    out_d;
    logic             jclk_q,   jclk_d;
    logic             load_n_q, load_n_d;
    logic             busy_q,   busy_d;
    logic             fv_q,     fv_d;
    logic             chg_q,    chg_d;
    logic             tick;
    logic             start_frame;

    // One tick every div+1 cycles, using the divisor captured at frame start.
    assign tick = (cnt_q == div_q);

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        cnt_d       = tick ? '0 : cnt_q + 1'b1;
        tcnt_d      = tcnt_q;
        pend_d      = pend_q | scan_req_i;
        raw_d       = raw_q;
        prev_d      = prev_q;
        out_d       = out_q;
        jclk_d      = jclk_q;
        load_n_d    = load_n_q;
        fv_d        = 1'b0;
        chg_d       = 1'b0;
        start_frame = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (continuous_i || pend_q || scan_req_i) begin
                    start_frame = 1'b1;
                end
            end
            ST_LOAD: begin
                if (tick) begin
                    if (tcnt_q[0]) begin
                        state_d  = ST_SHIFT;
                        tcnt_d   = '0;
                        load_n_d = 1'b1;
                    end else begin
                        tcnt_d = tcnt_q + 5'd1;
                    end
                end
            end
            ST_SHIFT: begin
                // Even ticks sample and raise the shift clock, odd ticks lower it.
                if (tick) begin
                    tcnt_d = tcnt_q + 5'd1;
                    if (!tcnt_q[0]) begin
                        raw_d  = {raw_q[14:0], joy_data_i};
                        jclk_d = 1'b1;
                    end else begin
                        jclk_d = 1'b0;
                        if (tcnt_q == 5'd31) begin
                            state_d = ST_COMMIT;
                        end
                    end
                end
            end
            ST_COMMIT: begin
                fv_d   = 1'b1;
                prev_d = raw_q;
                if (!FILTER || (raw_q == prev_q)) begin
                    out_d = raw_q;
                    chg_d = (raw_q != out_q);
                end
                if (continuous_i || pend_q) begin
                    start_frame = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Frame start absorbs any outstanding request and re-captures the divisor.
        if (start_frame) begin
            state_d  = ST_LOAD;
            div_d    = div_i;
            cnt_d    = '0;
            tcnt_d   = '0;
            load_n_d = 1'b0;
            jclk_d   = 1'b0;
            pend_d   = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            cnt_q    <= '0;
            tcnt_q   <= '0;
            pend_q   <= 1'b0;
            raw_q    <= 16'hFFFF;
            prev_q   <= 16'hFFFF;
            out_q    <= 16'hFFFF;
            jclk_q   <= 1'b0;
            load_n_q <= 1'b1;
            busy_q   <= 1'b0;
            fv_q     <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            tcnt_q   <= tcnt_d;
            pend_q   <= pend_d;
            raw_q    <= raw_d;
            prev_q   <= prev_d;
            out_q    <= out_d;
            jclk_q   <= jclk_d;
            load_n_q <= load_n_d;
            busy_q   <= busy_d;
            fv_q     <= fv_d;
            chg_q    <= chg_d;
        end
    end

    // First sample lands in bit 15, so the upper byte is joy1 in start..up order.
    assign joy1_o        = out_q[15:8];
    assign joy2_o        = out_q[7:0];
    assign joy_clk_o     = jclk_q;
    assign joy_load_n_o  = load_n_q;
    assign scan_busy_o   = busy_q;
    assign frame_valid_o = fv_q;
    assign changed_o     = chg_q;

endmodule

// File: tb/tb_joy_scan_ctrl.sv
// Bench for joy_scan_ctrl: a chain model feeds two DUTs (unfiltered and filtered);
// expected frames are queued at frame start and popped on each frame_valid pulse.
module tb_joy_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] div_i = 8'd0;
    logic       continuous_i = 1'b0;
    logic       scan_req_i = 1'b0;
    logic       joy_data;

    logic       jc0, ln0, busy0, fv0, ch0;
    logic       jc1, ln1, busy1, fv1, ch1;
    logic [7:0] j1_0, j2_0, j1_1, j2_1;

    always #5 clk = ~clk;

    joy_scan_ctrl #(.DIV_W(8), .FILTER(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .div_i(div_i), .continuous_i(continuous_i),
        .scan_req_i(scan_req_i), .joy_data_i(joy_data), .joy_clk_o(jc0),
        .joy_load_n_o(ln0), .scan_busy_o(busy0), .joy1_o(j1_0), .joy2_o(j2_0),
        .frame_valid_o(fv0), .changed_o(ch0)
    );

    joy_scan_ctrl #(.DIV_W(8), .FILTER(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .div_i(div_i), .continuous_i(continuous_i),
        .scan_req_i(scan_req_i), .joy_data_i(joy_data), .joy_clk_o(jc1),
        .joy_load_n_o(ln1), .scan_busy_o(busy1), .joy1_o(j1_1), .joy2_o(j2_1),
        .frame_valid_o(fv1), .changed_o(ch1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: {expected 16-bit output, expected changed}
    logic [16:0] q0[$];
    logic [16:0] q1[$];
    logic [15:0] m_prev [2];
    logic [15:0] m_out [2];

    // Chain model and reference: load on load_n low, shift on each rising shift clock.
    logic [15:0] sr = 16'hFFFF;
    logic [15:0] pat = 16'hFFFF;
    logic [15:0] last_pat = 16'hFFFF;
    logic [15:0] force_pat = 16'hFFFF;
    logic        force_en = 1'b1;
    logic        pl_ln = 1'b1;
    logic        pl_jc = 1'b0;

    assign joy_data = sr[15];

    always @(negedge clk) begin
        if (rst_i) begin
            sr = 16'hFFFF;
            q0.delete();
            q1.delete();
            for (int f = 0; f < 2; f++) begin
                m_prev[f] = 16'hFFFF;
                m_out[f]  = 16'hFFFF;
            end
            pl_ln = 1'b1;
            pl_jc = 1'b0;
        end else begin
            if (!ln0) begin
                if (pl_ln) begin
                    if (force_en) pat = force_pat;
                    else if ($urandom_range(0, 1) == 1) pat = last_pat;
                    else pat = 16'($urandom);
                    last_pat = pat;
                    for (int f = 0; f < 2; f++) begin
                        logic chg;
                        chg = 1'b0;
                        if (f == 0 || pat == m_prev[f]) begin
                            chg = (pat != m_out[f]);
                            m_out[f] = pat;
                        end
                        m_prev[f] = pat;
                        if (f == 0) q0.push_back({m_out[f], chg});
                        else        q1.push_back({m_out[f], chg});
                    end
                end
                sr = pat;
            end else if (jc0 && !pl_jc) begin
                sr = {sr[14:0], 1'b1};
            end
            pl_ln = ln0;
            pl_jc = jc0;
        end
    end

    logic [7:0] div_at_edge = 8'd0;
    always @(posedge clk) div_at_edge <= div_i;

    // Monitor: frame timing and scoreboard pops.
    int   frame_len = 0, low_cnt = 0, hi_cnt = 0, rises = 0, fdiv = 0;
    int   frames_started = 0;
    logic in_frame = 1'b0;
    logic pm_ln = 1'b1, pm_jc = 1'b0;

    always @(negedge clk) begin
        logic fall, end_evt;
        logic [16:0] e;
        if (rst_i) begin
            in_frame = 1'b0;
            pm_ln    = 1'b1;
            pm_jc    = 1'b0;
        end else begin
            fall    = pm_ln && !ln0;
            end_evt = in_frame && (fall || !busy0);
            if (end_evt) begin
                chk("frame_len", frame_len, 34 * (fdiv + 1) + 1);
                chk("clk_rises", rises, 16);
                chk("ctrl_eq", {ln1, jc1, busy1}, {ln0, jc0, busy0});
                in_frame = 1'b0;
            end
            if (end_evt || fv0) chk("fv0_timing", fv0, end_evt);
            if (end_evt || fv1) chk("fv1_timing", fv1, end_evt);
            if (ch0) chk("chg0_alone", fv0, 1);
            if (ch1) chk("chg1_alone", fv1, 1);
            if (fv0) begin
                if (q0.size() == 0) chk("sb0_nonempty", q0.size(), 1);
                else begin
                    e = q0.pop_front();
                    chk("joy0_out", {j1_0, j2_0}, e[16:1]);
                    chk("joy0_chg", ch0, e[0]);
                end
            end
            if (fv1) begin
                if (q1.size() == 0) chk("sb1_nonempty", q1.size(), 1);
                else begin
                    e = q1.pop_front();
                    chk("joy1_out", {j1_1, j2_1}, e[16:1]);
                    chk("joy1_chg", ch1, e[0]);
                end
            end
            if (fall) begin
                in_frame  = 1'b1;
                fdiv      = int'(div_at_edge);
                frame_len = 0;
                low_cnt   = 0;
                rises     = 0;
                hi_cnt    = 0;
                frames_started++;
            end
            if (in_frame) frame_len++;
            if (!ln0) low_cnt++;
            if (ln0 && !pm_ln && in_frame) chk("load_low", low_cnt, 2 * (fdiv + 1));
            if (jc0 && !pm_jc) begin
                rises++;
                hi_cnt = 0;
            end
            if (jc0) hi_cnt++;
            if (!jc0 && pm_jc) chk("clk_high", hi_cnt, fdiv + 1);
            pm_ln = ln0;
            pm_jc = jc0;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic req_pulse(input bit chk_lat);
        scan_req_i = 1'b1;
        @(negedge clk);
        if (chk_lat) chk("req_latency", {ln0, ln1}, 2'b00);
        #1 scan_req_i = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int lowc = 0;
        int n = 0;
        while (lowc < 3 && n < maxc) begin
            @(negedge clk);
            n++;
            if (!busy0) lowc++;
            else lowc = 0;
        end
        #1;
        chk("idle_reached", lowc >= 3, 1);
    endtask

    initial begin
        int base;
        repeat (2) @(negedge clk);
        chk("rst_joy", {j1_0, j2_0, j1_1, j2_1}, 32'hFFFF_FFFF);
        chk("rst_ctrl", {ln0, jc0, busy0, fv0, ch0}, 5'b10000);
        #1 rst_i = 1'b0;
        cycles(2);

        // Single shot, div=1, twice with the same pattern
        div_i = 8'd1;
        force_en = 1'b1;
        force_pat = 16'h7FFE;
        req_pulse(1'b1);
        wait_idle(200);
        chk("shot1_joy0", {j1_0, j2_0}, 16'h7FFE);
        chk("shot1_joy1", {j1_1, j2_1}, 16'hFFFF);
        req_pulse(1'b1);
        wait_idle(200);
        chk("shot2_joy1", {j1_1, j2_1}, 16'h7FFE);

        // Two requests while busy give exactly one extra frame
        force_pat = 16'hA5C3;
        base = frames_started;
        req_pulse(1'b1);
        cycles(10);
        req_pulse(1'b0);
        cycles(10);
        req_pulse(1'b0);
        wait_idle(400);
        chk("pending_frames", frames_started - base, 2);

        // Continuous, div=3
        force_en = 1'b0;
        div_i = 8'd3;
        continuous_i = 1'b1;
        base = frames_started;
        cycles(4 * 137 + 10);
        continuous_i = 1'b0;
        wait_idle(400);
        chk("cont_frames", frames_started - base, 5);

        // Divisor change mid-frame applies at next frame start only
        div_i = 8'd0;
        continuous_i = 1'b1;
        cycles(5);
        div_i = 8'd5;
        cycles(60);
        continuous_i = 1'b0;
        wait_idle(600);

        // Randomised traffic
        repeat (25) begin
            case ($urandom_range(0, 3))
                0: div_i = 8'($urandom_range(0, 3));
                1: continuous_i = ~continuous_i;
                default: req_pulse(1'b0);
            endcase
            cycles($urandom_range(5, 120));
        end
        continuous_i = 1'b0;
        wait_idle(1000);

        // Asynchronous reset in the middle of SHIFT
        force_en = 1'b1;
        force_pat = 16'h0F0F;
        div_i = 8'd1;
        req_pulse(1'b1);
        cycles(20);
        chk("pre_rst_busy", busy0, 1);
        #1 rst_i = 1'b1;
        #1;
        chk("arst_joy", {j1_0, j2_0, j1_1, j2_1}, 32'hFFFF_FFFF);
        chk("arst_ctrl", {ln0, jc0, busy0, ln1, jc1, busy1}, 6'b100100);
        @(negedge clk);
        #1 rst_i = 1'b0;
        cycles(2);
        force_pat = 16'h1234;
        req_pulse(1'b1);
        wait_idle(200);
        chk("post_rst_joy0", {j1_0, j2_0}, 16'h1234);
        chk("post_rst_joy1", {j1_1, j2_1}, 16'hFFFF);

        chk("sb0_drained", q0.size(), 0);
        chk("sb1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/joy_scan_ctrl.md
# joy_scan_ctrl

Scan controller for the two-joystick serial shift-register chain (2×8 buttons behind a parallel-in/serial-out register pair). It generates the chain's load and shift clock from a programmable divisor, sequences load/shift/commit frames in single-shot or free-running mode, and deserialises the 16 bits. It optionally filters inputs by two-frame agreement and publishes active-low button vectors with per-frame strobes to the core's input logic.

## Interface
- `DIV_W`, 8: width of divisor input.
- `FILTER`, 1: 1 = outputs update only when two consecutive raw frames agree; 0 = update every frame.
- `clk_i` in 1: system clock.
- `rst_i` in 1: reset; one clock; asynchronous, active-high.
- `div_i` in DIV_W: tick period minus 1 in `clk_i` cycles; latched at each frame start.
- `continuous_i` in 1: 1 = back-to-back frames; 0 = frames only on request.
- `scan_req_i` in 1: single-shot frame request, level-sampled each cycle.
- `joy_data_i` in 1: serial data from chain.
- `joy_clk_o` out 1: shift clock to chain.
- `joy_load_n_o` out 1: active-low parallel load to chain.
- `scan_busy_o` out 1: high from LOAD entry through COMMIT.
- `joy1_o`, `joy2_o` out 8 each: active-low buttons; bit 0..7 = up, down, left, right, fire1, fire2, fire3, start.
- `frame_valid_o` out 1: one-cycle pulse per completed frame.
- `changed_o` out 1: one-cycle pulse when `joy1_o`/`joy2_o` change value.

## Operation
- States: IDLE, LOAD, SHIFT, COMMIT.
- Tick generator: counter cleared on LOAD entry; asserts tick when count == latched div, then reloads 0. Tick period = div+1 cycles. div = 0 means a tick every cycle.
- IDLE → LOAD when `continuous_i`=1 or a request is pending. Latch `div_i`. Clear the pending flag.
- LOAD: `joy_load_n_o`=0, `joy_clk_o`=0 for 2 ticks, then → SHIFT with `joy_load_n_o`=1.
- SHIFT: 16 bit periods of 2 ticks each.
  - First tick of a period: sample `joy_data_i` and drive `joy_clk_o`=1.
  - Second tick: drive `joy_clk_o`=0.
  - Sample n (0-based) goes to raw bit 15−n. Raw[15:8] → joy1 start..up (sample 0 = joy1 start). Raw[7:0] → joy2 start..up.
  - After the 16th period → COMMIT.
- COMMIT (exactly 1 cycle):
  - Update if FILTER=0, or if raw == prev_raw.
  - On update: `{joy1_o, joy2_o}` ← raw (raw[15:8] reordered to joy1 bits 7..0, likewise joy2).
  - prev_raw ← raw.
  - Next state: LOAD if `continuous_i`=1 or a request is pending (re-latch div); else IDLE.
- Requests:
  - `scan_req_i`=1 in IDLE with `continuous_i`=0 starts a frame next cycle.
  - `scan_req_i`=1 while busy sets a single pending flag (no counting).
  - In continuous mode, requests are absorbed: the flag is cleared at each frame start.
- Dropping `continuous_i` mid-frame: current frame completes, then IDLE unless a request is pending.
- `div_i` changes mid-frame take effect at the next frame start only.

## Timing
- Reset values (immediate, asynchronous):
  - IDLE; `joy_clk_o`=0, `joy_load_n_o`=1, `scan_busy_o`=0.
  - `joy1_o`=`joy2_o`=8'hFF, prev_raw=16'hFFFF.
  - `frame_valid_o`=`changed_o`=0; pending cleared.
- Reset mid-frame aborts the frame with no output update.
- Request-to-load latency: `scan_req_i` high at edge k in IDLE → `joy_load_n_o`=0 from cycle k+1.
- LOAD lasts 2(div+1) cycles; SHIFT 32(div+1) cycles; COMMIT 1 cycle.
- Continuous frame period = 34(div+1)+1 cycles.
- `frame_valid_o`, `changed_o` and new `joy*_o` values appear registered the cycle after COMMIT.
- `frame_valid_o` pulses every frame, including frames rejected by the filter.
- `changed_o` pulses only when the registered outputs actually differ.
- All outputs are registered; no combinational path from input to output.

## Test plan
- Reset: assert `rst_i` mid-SHIFT → `joy*_o`=FF, `joy_load_n_o`=1, `joy_clk_o`=0, `scan_busy_o`=0 with no clock edge; the next request starts a fresh LOAD.
- Single shot, FILTER=0, div=1, chain model returns serial 0111_1111_1111_1110 (first bit first) → after 69 busy cycles, `joy1_o`=8'h7F (start pressed), `joy2_o`=8'hFE (up pressed); `frame_valid_o` and `changed_o` pulse once; `joy_load_n_o` low 4 cycles.
- FILTER=1, same pattern on two requests → first frame: `frame_valid_o` pulses, outputs stay FF, `changed_o`=0. Second frame: outputs 7F/FE, `changed_o`=1.
- Continuous, div=3 → `joy_load_n_o` falling edges exactly 137 cycles apart; 16 `joy_clk_o` rising edges per frame, high 4 cycles each.
- Pending request: pulse `scan_req_i` twice during a busy frame (continuous=0) → exactly one extra frame follows COMMIT, then IDLE.
- div change: set div 0→5 mid-frame → current frame keeps 1-cycle ticks; next frame uses 6-cycle ticks.
